// File: rtl/memsum_pkg.sv
// Shared types for the memory-based sum sequencer: state encoding, register map
// and the per-state output decode used by the controller.
package memsum_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INIT1,
      INIT2,
      INIT3,
      INC,
      CMP,
      ACC,
      OUT,
      DONE,
      ERR
   } state_e;

   localparam logic [1:0] REG_ZERO = 2'd0;
   localparam logic [1:0] REG_ONE  = 2'd1;
   localparam logic [1:0] REG_I    = 2'd2;
   localparam logic [1:0] REG_SUM  = 2'd3;

   localparam logic RSRC_ALU = 1'b0;
   localparam logic RSRC_IMM = 1'b1;

   // The immediate is only ever 0 or 1, so one bit is carried and widened at the port.
   typedef struct packed {
      logic       busy;
      logic       done;
      logic       err;
      logic       wr_en;
      logic [1:0] wr_addr;
      logic [1:0] rd_addr0;
      logic [1:0] rd_addr1;
      logic       rsrc_sel;
      logic       imm_one;
      logic       out_buf_en;
   } ctrl_t;

   function automatic ctrl_t decode(state_e s);
      ctrl_t c;
      c          = '0;
      c.rd_addr0 = REG_ZERO;
      c.rd_addr1 = REG_ZERO;
      c.rsrc_sel = RSRC_ALU;
      case (s)
         INIT1: begin
            c.wr_en    = 1'b1;
            c.wr_addr  = REG_ONE;
            c.rsrc_sel = RSRC_IMM;
            c.imm_one  = 1'b1;
         end
         INIT2: begin
            c.wr_en    = 1'b1;
            c.wr_addr  = REG_I;
            c.rsrc_sel = RSRC_IMM;
         end
         INIT3: begin
            c.wr_en    = 1'b1;
            c.wr_addr  = REG_SUM;
            c.rsrc_sel = RSRC_IMM;
         end
         INC: begin
            c.wr_en    = 1'b1;
            c.wr_addr  = REG_I;
            c.rd_addr0 = REG_I;
            c.rd_addr1 = REG_ONE;
         end
         CMP: c.rd_addr1 = REG_I;
         ACC: begin
            c.wr_en    = 1'b1;
            c.wr_addr  = REG_SUM;
            c.rd_addr0 = REG_SUM;
            c.rd_addr1 = REG_I;
         end
         OUT: begin
            c.rd_addr0   = REG_SUM;
            c.out_buf_en = 1'b1;
         end
         DONE:    c.done = 1'b1;
         ERR:     c.err  = 1'b1;
         default: ;
      endcase
      c.busy = (s != IDLE);
      return c;
   endfunction

endpackage

// File: rtl/memsum_seq_ctrl_if.sv
// Host handshake plus datapath control bundle between the sequencer and the
// register-file/ALU datapath.
interface memsum_seq_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              iStart;
   logic              iAbort;
   logic              iLe;
   logic              oBusy;
   logic              oDone;
   logic              oErr;
   logic              oWrEn;
   logic [1:0]        oWrAddr;
   logic [1:0]        oRdAddr0;
   logic [1:0]        oRdAddr1;
   logic              oRSrcSel;
   logic [DATA_W-1:0] oImm;
   logic              oOutBufEn;

   modport master (
      output iStart, iAbort, iLe,
      input  oBusy, oDone, oErr, oWrEn, oWrAddr, oRdAddr0, oRdAddr1,
             oRSrcSel, oImm, oOutBufEn
   );

   modport slave (
      input  iStart, iAbort, iLe,
      output oBusy, oDone, oErr, oWrEn, oWrAddr, oRdAddr0, oRdAddr1,
             oRSrcSel, oImm, oOutBufEn
   );
endinterface

// File: rtl/memsum_iter_cnt.sv
// Accumulate-iteration watchdog counter: synchronous clear, increment that
// saturates at MAX_ITER, and an equals-MAX_ITER flag.
module memsum_iter_cnt #(
   parameter int MAX_ITER = 255
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic clr,
   input  logic inc,
   output logic at_max
);
   localparam int               CNT_W   = $clog2(MAX_ITER + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == CNT_MAX);

endmodule

// File: rtl/memsum_seq_ctrl.sv
// Start/done sequencer computing sum(1..N) on the register-file datapath, with
// host handshake, abort and an iteration watchdog.
module memsum_seq_ctrl
   import memsum_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_ITER = 255
) (
   input  logic              iClk,
   input  logic              iRst_n,
   memsum_seq_ctrl_if.slave  bus
);
   state_e state;
   state_e state_nx;
   ctrl_t  ctrl;
   logic   cnt_max;
   logic   abortable;

   memsum_iter_cnt #(
      .MAX_ITER(MAX_ITER)
   ) u_iter_cnt (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .clr    (state == INIT2),
      .inc    (state == ACC),
      .at_max (cnt_max)
   );

   // DONE and ERR pulses always complete; abort only cuts short a running sequence.
   assign abortable = (state != IDLE) && (state != DONE) && (state != ERR);

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (bus.iStart) state_nx = INIT1;
         INIT1: state_nx = INIT2;
         INIT2: state_nx = INIT3;
         INIT3: state_nx = INC;
         INC:   state_nx = CMP;
         CMP: begin
            if (!bus.iLe)    state_nx = OUT;
            else if (cnt_max) state_nx = ERR;
            else              state_nx = ACC;
         end
         ACC:     state_nx = INC;
         OUT:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (bus.iAbort && abortable) state_nx = IDLE;
   end

   // Outputs are registered from the decode of the next state, so they stay a
   // pure function of the current state while coming straight out of flops.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state <= IDLE;
         ctrl  <= '0;
      end else begin
         state <= state_nx;
         ctrl  <= decode(state_nx);
      end
   end

   assign bus.oBusy     = ctrl.busy;
   assign bus.oDone     = ctrl.done;
   assign bus.oErr      = ctrl.err;
   assign bus.oWrEn     = ctrl.wr_en;
   assign bus.oWrAddr   = ctrl.wr_addr;
   assign bus.oRdAddr0  = ctrl.rd_addr0;
   assign bus.oRdAddr1  = ctrl.rd_addr1;
   assign bus.oRSrcSel  = ctrl.rsrc_sel;
   assign bus.oImm      = DATA_W'(ctrl.imm_one);
   assign bus.oOutBufEn = ctrl.out_buf_en;

endmodule

// File: tb/tb_memsum_seq_ctrl.sv
// Directed bench for memsum_seq_ctrl: a behavioural register-file datapath closes
// the loop, and timing, sums, aborts, resets and the watchdog are checked.
module tb_memsum_seq_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memsum_seq_ctrl_if #(.DATA_W(8)) bus1 ();
   memsum_seq_ctrl_if #(.DATA_W(8)) bus2 ();

   memsum_seq_ctrl #(.DATA_W(8), .MAX_ITER(255)) u_dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus1)
   );

   memsum_seq_ctrl #(.DATA_W(8), .MAX_ITER(4)) u_dut_wd (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus2)
   );

   // Datapath model: 4-entry RF (R0 reads 0), adder, write mux, comparator, output buffer.
   logic [7:0] rf [4];
   logic [7:0] limit;
   logic [7:0] obuf;
   logic [7:0] rd0_data;
   logic [7:0] rd1_data;

   always_comb begin
      rd0_data = (bus1.oRdAddr0 == 2'd0) ? 8'd0 : rf[bus1.oRdAddr0];
      rd1_data = (bus1.oRdAddr1 == 2'd0) ? 8'd0 : rf[bus1.oRdAddr1];
   end

   assign bus1.iLe = (rd1_data <= limit);
   assign bus2.iLe = 1'b1;

   always @(posedge clk) begin
      if (bus1.oWrEn && bus1.oWrAddr != 2'd0)
         rf[bus1.oWrAddr] <= bus1.oRSrcSel ? bus1.oImm : 8'(rd0_data + rd1_data);
      if (bus1.oOutBufEn)
         obuf <= rd0_data;
   end

   // Edge index and output monitors, sampled on the falling edge.
   int edge_n    = 0;
   int done1     = 0;
   int err1      = 0;
   int acc1      = 0;
   int busy1     = 0;
   int done_edge = 0;
   int done2     = 0;
   int err2      = 0;
   int acc2      = 0;
   int err_edge2 = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(negedge clk) begin
      if (bus1.oDone) begin
         done1     <= done1 + 1;
         done_edge <= edge_n;
      end
      if (bus1.oErr)  err1  <= err1 + 1;
      if (bus1.oBusy) busy1 <= busy1 + 1;
      if (bus1.oWrEn && bus1.oWrAddr == 2'd3 && !bus1.oRSrcSel) acc1 <= acc1 + 1;
      if (bus2.oDone) done2 <= done2 + 1;
      if (bus2.oErr) begin
         err2      <= err2 + 1;
         err_edge2 <= edge_n;
      end
      if (bus2.oWrEn && bus2.oWrAddr == 2'd3 && !bus2.oRSrcSel) acc2 <= acc2 + 1;
   end

   logic [19:0] outs1;
   logic [19:0] outs2;
   assign outs1 = {bus1.oBusy, bus1.oDone, bus1.oErr, bus1.oWrEn, bus1.oWrAddr, bus1.oRdAddr0,
                   bus1.oRdAddr1, bus1.oRSrcSel, bus1.oImm, bus1.oOutBufEn};
   assign outs2 = {bus2.oBusy, bus2.oDone, bus2.oErr, bus2.oWrEn, bus2.oWrAddr, bus2.oRdAddr0,
                   bus2.oRdAddr1, bus2.oRSrcSel, bus2.oImm, bus2.oOutBufEn};

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pulse iStart for one edge; k is the index of the edge that samples it.
   task automatic start1(input logic [7:0] n, output int k);
      limit       = n;
      bus1.iStart = 1'b1;
      tick();
      k           = edge_n;
      bus1.iStart = 1'b0;
   endtask

   initial begin
      int k;
      int b_done;
      int b_err;
      int b_acc;
      int b_busy;
      int seen;
      logic [19:0] init1_exp;

      bus1.iStart = 1'b0;
      bus1.iAbort = 1'b0;
      bus2.iStart = 1'b0;
      bus2.iAbort = 1'b0;
      limit       = 8'd0;
      init1_exp   = {1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 8'd1, 1'b0};

      ticks(2);
      check("reset_outs", 32'(outs1), 32'd0);
      check("reset_outs_wd", 32'(outs2), 32'd0);
      rst_n = 1'b1;
      ticks(2);
      check("idle_busy", 32'(bus1.oBusy), 32'd0);

      // N=10: 55 at edge k+36, ten accumulations, busy for 37 cycles.
      b_done = done1; b_err = err1; b_acc = acc1; b_busy = busy1;
      start1(8'd10, k);
      check("init1_decode", 32'(outs1), 32'(init1_exp));
      ticks(40);
      check("n10_done_cnt", done1 - b_done, 1);
      check("n10_done_edge", done_edge, k + 36);
      check("n10_sum", 32'(obuf), 32'd55);
      check("n10_acc_writes", acc1 - b_acc, 10);
      check("n10_busy_cycles", busy1 - b_busy, 37);
      check("n10_err_cnt", err1 - b_err, 0);

      // N=0: result 0 at edge k+6, no accumulation.
      b_done = done1; b_acc = acc1;
      start1(8'd0, k);
      ticks(10);
      check("n0_done_cnt", done1 - b_done, 1);
      check("n0_done_edge", done_edge, k + 6);
      check("n0_sum", 32'(obuf), 32'd0);
      check("n0_acc_writes", acc1 - b_acc, 0);

      // Abort during the third ACC: idle next edge, no pulses, buffer keeps 0.
      b_done = done1; b_err = err1;
      start1(8'd10, k);
      seen = 0;
      for (int i = 0; i < 60 && seen < 3; i++) begin
         if (bus1.oWrEn && bus1.oWrAddr == 2'd3 && !bus1.oRSrcSel) seen++;
         if (seen < 3) tick();
      end
      check("abort_third_acc_seen", seen, 3);
      bus1.iAbort = 1'b1;
      tick();
      bus1.iAbort = 1'b0;
      check("abort_busy", 32'(bus1.oBusy), 32'd0);
      ticks(10);
      check("abort_done_cnt", done1 - b_done, 0);
      check("abort_err_cnt", err1 - b_err, 0);
      check("abort_buf_kept", 32'(obuf), 32'd0);
      start1(8'd10, k);
      ticks(40);
      check("after_abort_sum", 32'(obuf), 32'd55);
      check("after_abort_done_edge", done_edge, k + 36);

      // iStart re-pulsed in CMP and in OUT is ignored.
      b_done = done1;
      start1(8'd10, k);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick();
         if (bus1.oBusy && !bus1.oWrEn && bus1.oRdAddr1 == 2'd2) seen = 1;
      end
      check("cmp_reached", seen, 1);
      bus1.iStart = 1'b1;
      tick();
      bus1.iStart = 1'b0;
      seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
         tick();
         if (bus1.oOutBufEn) seen = 1;
      end
      check("out_reached", seen, 1);
      bus1.iStart = 1'b1;
      tick();
      bus1.iStart = 1'b0;
      ticks(10);
      check("restart_ign_done_cnt", done1 - b_done, 1);
      check("restart_ign_done_edge", done_edge, k + 36);
      check("restart_ign_sum", 32'(obuf), 32'd55);
      check("restart_ign_busy", 32'(bus1.oBusy), 32'd0);

      // iStart held through DONE: one IDLE cycle, then a new run.
      limit       = 8'd2;
      bus1.iStart = 1'b1;
      tick();
      k    = edge_n;
      seen = 0;
      for (int i = 0; i < 30 && seen == 0; i++) begin
         tick();
         if (bus1.oDone) seen = 1;
      end
      check("held_done_seen", seen, 1);
      check("held_done_edge", done_edge, k + 12);
      check("held_sum", 32'(obuf), 32'd3);
      tick();
      check("held_idle_gap", 32'(bus1.oBusy), 32'd0);
      tick();
      check("held_rerun_busy", 32'(bus1.oBusy), 32'd1);
      bus1.iStart = 1'b0;
      bus1.iAbort = 1'b1;
      tick();
      bus1.iAbort = 1'b0;
      check("held_abort_busy", 32'(bus1.oBusy), 32'd0);

      // N=23: 276 wraps to 20 in the 8-bit datapath.
      start1(8'd23, k);
      ticks(80);
      check("n23_wrap_sum", 32'(obuf), 32'd20);
      check("n23_done_edge", done_edge, k + 75);

      // Asynchronous reset mid-loop, then a fresh run.
      b_done = done1; b_err = err1;
      start1(8'd10, k);
      ticks(14);
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", 32'(outs1), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start1(8'd10, k);
      ticks(40);
      check("post_reset_sum", 32'(obuf), 32'd55);
      check("post_reset_done_edge", done_edge, k + 36);
      check("post_reset_done_cnt", done1 - b_done, 1);
      check("post_reset_err_cnt", err1 - b_err, 0);

      // Watchdog with MAX_ITER=4 and iLe stuck high.
      b_done = done2; b_err = err2; b_acc = acc2;
      bus2.iStart = 1'b1;
      tick();
      k           = edge_n;
      bus2.iStart = 1'b0;
      ticks(25);
      check("wd_acc_writes", acc2 - b_acc, 4);
      check("wd_err_cnt", err2 - b_err, 1);
      check("wd_err_edge", err_edge2, k + 17);
      check("wd_done_cnt", done2 - b_done, 0);
      check("wd_busy", 32'(bus2.oBusy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
